// File: rtl/misr_sig_checker.sv
// Compacts a window of 32-bit response words into a MISR signature and compares it with a golden value.
// Optional serial signature unload is enabled with `define MISR_SERIAL_UNLOAD_EN.
`timescale 1ns/1ps
module misr_sig_checker #(
    parameter int unsigned CNT_W = 16,
    parameter logic [31:0] SEED  = 32'h0000_0000
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             start,
    input  logic [CNT_W-1:0] window_len,
    input  logic [31:0]      golden,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      signature
`ifdef MISR_SERIAL_UNLOAD_EN
    ,
    output logic             sout,
    output logic             sout_valid
`endif
);

    localparam int unsigned SIG_W  = 32;
    localparam int unsigned BIT_W  = 5;
    localparam logic [SIG_W-1:0] TAPS = 32'h0001_0811;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPACT = 3'd1,
        COMPARE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    logic [SIG_W-1:0] misr;
    logic [CNT_W-1:0] cnt;
    logic [SIG_W-1:0] golden_q;
`ifdef MISR_SERIAL_UNLOAD_EN
    logic [SIG_W-1:0] shreg;
    logic [BIT_W-1:0] bitcnt;
`endif

    // x^32+x^16+x^11+x^4+1: shift up, fold bit 31 back into taps 0/4/11/16, then mix in the data word
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                  input logic [SIG_W-1:0] d);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? TAPS : '0) ^ d;
    endfunction

    assign signature = misr;

    always_ff @(posedge CK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            misr      <= SEED;
            cnt       <= '0;
            golden_q  <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b0;
`ifdef MISR_SERIAL_UNLOAD_EN
            shreg      <= '0;
            bitcnt     <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        misr     <= SEED;
                        cnt      <= window_len;
                        golden_q <= golden;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        if (window_len == '0) begin
                            state     <= COMPARE;
                            din_ready <= 1'b0;
                        end else begin
                            state     <= COMPACT;
                            din_ready <= 1'b1;
                        end
                    end
                end
                COMPACT: begin
                    // Leaving on cnt==1 means the counter never steps below zero
                    if (din_valid && din_ready) begin
                        misr <= misr_next(misr, din);
                        cnt  <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= COMPARE;
                            din_ready <= 1'b0;
                        end
                    end
                end
                COMPARE: begin
                    pass <= (misr == golden_q);
`ifdef MISR_SERIAL_UNLOAD_EN
                    state      <= UNLOAD;
                    shreg      <= {misr[SIG_W-2:0], 1'b0};
                    sout       <= misr[SIG_W-1];
                    sout_valid <= 1'b1;
                    bitcnt     <= BIT_W'(SIG_W - 1);
`else
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`endif
                end
`ifdef MISR_SERIAL_UNLOAD_EN
                UNLOAD: begin
                    // Shift a private copy so signature keeps the compacted value
                    if (bitcnt == '0) begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        sout   <= shreg[SIG_W-1];
                        shreg  <= {shreg[SIG_W-2:0], 1'b0};
                        bitcnt <= bitcnt - BIT_W'(1);
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_misr_sig_checker.sv
// Self-checking bench for misr_sig_checker: directed steps plus randomized windows against a polynomial model.
`timescale 1ns/1ps
module tb_misr_sig_checker;

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] SEED  = 32'h0000_0000;

    logic             CK = 1'b0;
    logic             RESET = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] window_len = '0;
    logic [31:0]      golden = '0;
    logic [31:0]      din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [31:0]      signature;
`ifdef MISR_SERIAL_UNLOAD_EN
    logic             sout;
    logic             sout_valid;
`endif

    int checks = 0;
    int errors = 0;

    misr_sig_checker #(.CNT_W(CNT_W), .SEED(SEED)) dut (
        .CK         (CK),
        .RESET      (RESET),
        .start      (start),
        .window_len (window_len),
        .golden     (golden),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
`ifdef MISR_SERIAL_UNLOAD_EN
        ,
        .sout       (sout),
        .sout_valid (sout_valid)
`endif
    );

    always #5 CK = ~CK;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Signature as a GF(2) polynomial: multiply by x modulo P(x), then add the data word
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] d);
        logic [32:0] p;
        p = {s, 1'b0};
        if (p[32]) p = p ^ 33'h1_0001_0811;
        return p[31:0] ^ d;
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Called in the COMPARE cycle; returns in the DONE cycle
    task automatic finish_check(input logic [31:0] exp_sig, input logic exp_pass);
        logic [31:0] bits;
        chk("done_in_compare", done, 0);
        chk("busy_in_compare", busy, 1);
        chk("ready_in_compare", din_ready, 0);
`ifdef MISR_SERIAL_UNLOAD_EN
        tick();
        bits = '0;
        for (int b = 31; b >= 0; b--) begin
            if (sout_valid !== 1'b1 || done !== 1'b0) begin
                chk("sout_valid", {30'd0, done, sout_valid}, 32'd1);
            end
            bits[b] = sout;
            chk("sig_hold_unload", signature, exp_sig);
            tick();
        end
        chk("sout_stream", bits, exp_sig);
        chk("sout_valid_end", sout_valid, 0);
`else
        tick();
`endif
        chk("done_pulse", done, 1);
        chk("pass", pass, exp_pass);
        chk("signature", signature, exp_sig);
        chk("busy_done", busy, 0);
    endtask

    task automatic run(input int wl, input bit gaps, input bit match, input bit intrude);
        logic [31:0] words[$];
        logic [31:0] exp_sig;
        logic [31:0] gold;
        int idx;
        int cyc;
        exp_sig = SEED;
        for (int i = 0; i < wl; i++) begin
            words.push_back($urandom);
            exp_sig = ref_step(exp_sig, words[i]);
        end
        gold = match ? exp_sig : exp_sig ^ (32'h1 << $urandom_range(31, 0));
        window_len = CNT_W'(wl);
        golden = gold;
        start = 1'b1;
        tick();
        start = 1'b0;
        window_len = CNT_W'($urandom);
        golden = $urandom;
        chk("busy_after_start", busy, 1);
        idx = 0;
        cyc = 0;
        while (idx < wl && cyc < 400) begin
            din_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            din = din_valid ? words[idx] : $urandom;
            if (intrude && cyc == 1) begin
                start = 1'b1;
                window_len = CNT_W'(3);
                golden = $urandom;
            end
            chk("ready_compact", din_ready, 1);
            if (din_valid) idx++;
            tick();
            start = 1'b0;
            cyc++;
        end
        if (idx < wl) chk("compact_timeout", 32'(idx), 32'(wl));
        din_valid = 1'b1;
        din = $urandom;
        finish_check(exp_sig, match);
        din_valid = 1'b0;
        tick();
        chk("done_one_cycle", done, 0);
        chk("pass_hold", pass, match);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_signature", signature, SEED);
        chk("rst_pass", pass, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", din_ready, 0);
        RESET = 1'b1;
        tick();
        tick();

        // Single word, seed 0
        window_len = CNT_W'(1);
        golden = 32'h0000_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        din = 32'h0000_0001;
        din_valid = 1'b1;
        chk("ready_single", din_ready, 1);
        tick();
        din_valid = 1'b0;
        chk("sig_single", signature, 32'h0000_0001);
        finish_check(32'h0000_0001, 1'b1);
        tick();

        // Feedback taps from state 0x8000_0000
        window_len = CNT_W'(2);
        golden = 32'h0001_0811;
        start = 1'b1;
        tick();
        start = 1'b0;
        din = 32'h8000_0000;
        din_valid = 1'b1;
        tick();
        chk("sig_msb", signature, 32'h8000_0000);
        din = 32'h0000_0000;
        tick();
        din_valid = 1'b0;
        finish_check(32'h0001_0811, 1'b1);
        tick();

        // Empty window compares the seed
        run(0, 1'b0, 1'b1, 1'b0);
        run(0, 1'b0, 1'b0, 1'b0);

        // Gapped window of 4 with an ignored mid-run start
        run(4, 1'b1, 1'b1, 1'b1);

        // Randomized windows
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(20, 1), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)));
        end

        // Start during DONE is ignored, then accepted from IDLE
        window_len = '0;
        golden = SEED;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_check(SEED, 1'b1);
        start = 1'b1;
        window_len = '0;
        golden = SEED ^ 32'h1;
        tick();
        chk("start_in_done_busy", busy, 0);
        chk("start_in_done_done", done, 0);
        chk("start_in_done_pass", pass, 1);
        tick();
        start = 1'b0;
        finish_check(SEED, 1'b0);
        tick();

        // Reset mid-run aborts without a done pulse
        window_len = CNT_W'(5);
        golden = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        din_valid = 1'b1;
        din = $urandom;
        tick();
        din = $urandom;
        tick();
        din_valid = 1'b0;
        RESET = 1'b0;
        #1;
        chk("abort_signature", signature, SEED);
        chk("abort_busy", busy, 0);
        chk("abort_ready", din_ready, 0);
        chk("abort_pass", pass, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        RESET = 1'b1;
        tick();
        chk("idle_after_reset", busy, 0);
        run(3, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/misr_sig_checker.md
MISR_SIG_CHECKER -- requirements
Module: misr_sig_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which is the width of the compaction window counter.
REQ-002 SHALL have parameter SEED, default 32'h0000_0000, which is the MISR value loaded on start.
REQ-003 SHALL have port CK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle request to begin a compaction run.
REQ-006 SHALL have port window_len, input, CNT_W bits, the number of accepted data words to compact; sampled on start.
REQ-007 SHALL have port golden, input, 32 bits, the expected signature; sampled on start.
REQ-008 SHALL have port din, input, 32 bits, the parallel response word to compact.
REQ-009 SHALL have port din_valid, input, 1 bit, which qualifies din.
REQ-010 SHALL have port din_ready, output, 1 bit, high only in COMPACT.
REQ-011 SHALL have port busy, output, 1 bit, high in COMPACT and COMPARE.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse when the verdict is valid.
REQ-013 SHALL have port pass, output, 1 bit, the verdict (signature == golden), held until the next start.
REQ-014 SHALL have port signature, output, 32 bits, the current MISR register contents.

Function
REQ-015 SHALL implement the MISR polynomial x^32+x^16+x^11+x^4+1: next[0]=s[31]^d[0]; next[4]=s[3]^s[31]^d[4]; next[11]=s[10]^s[31]^d[11]; next[16]=s[15]^s[31]^d[16]; every other bit i gives next[i]=s[i-1]^d[i].
REQ-016 SHALL update the MISR only on a cycle where din_valid && din_ready (an accepted word); the MISR SHALL hold otherwise.
REQ-017 SHALL have FSM states IDLE, COMPACT, COMPARE, DONE.
REQ-018 IDLE->COMPACT on start: MISR<=SEED, counter<=window_len, latch golden, pass<=0.
REQ-019 SHALL, when start arrives with window_len==0, go IDLE->COMPARE directly and compare SEED against golden.
REQ-020 In COMPACT, SHALL decrement the counter per accepted word; the word that takes the counter to 0 is compacted and the next state is COMPARE.
REQ-021 In COMPARE (one cycle), SHALL register pass<=(MISR==golden_latched) and go to DONE.
REQ-022 In DONE (one cycle), SHALL assert done=1 and then return to IDLE; pass stays valid.
REQ-023 Latency: done SHALL assert exactly 2 cycles after the final accepted word.
REQ-024 SHALL ignore start outside IDLE (no restart, no change to the latched values).
REQ-025 SHALL accept a start in the same cycle that done is high only in the next cycle (IDLE); a start during DONE is ignored.
REQ-026 Counter wrap: SHALL not underflow; window_len = 2^CNT_W-1 SHALL compact exactly that many words.

Reset
REQ-027 RESET low SHALL asynchronously force state=IDLE, MISR=SEED, counter=0, golden_latched=0, pass=0, done=0, busy=0, din_ready=0.
REQ-028 RESET asserted mid-run SHALL abort the run with no done pulse; operation resumes on the first start after RESET deasserts.

Configuration
REQ-029 Macro MISR_SERIAL_UNLOAD_EN: when defined, SHALL add state UNLOAD between COMPARE and DONE, plus output ports sout (1 bit) and sout_valid (1 bit).
REQ-030 With MISR_SERIAL_UNLOAD_EN: UNLOAD SHALL shift the signature out MSB first over 32 cycles with sout_valid=1; the signature output SHALL keep the pre-shift value; done asserts on the cycle after bit 0; latency from the final word to done becomes 34 cycles.
REQ-031 Without MISR_SERIAL_UNLOAD_EN: SHALL have no sout/sout_valid ports and no UNLOAD state; behaviour is as in REQ-017..026.

Verification
REQ-032 Reset, SEED=0: start, window_len=1, din=32'h0000_0001, golden=32'h0000_0001 -> signature=32'h0000_0001, pass=1, done 2 cycles after the word.
REQ-033 Feedback taps: MISR=32'h8000_0000 state, din=0 accepted -> signature=32'h0001_0811.
REQ-034 window_len=0, golden=SEED -> pass=1, done 2 cycles after start; golden=SEED^1 -> pass=0.
REQ-035 window_len=4 with din_valid toggled (gaps) -> exactly 4 words compacted; signature matches the software model; extra words are not accepted (din_ready=0).
REQ-036 RESET pulled low during COMPACT after 2 words -> all outputs at reset values, no done; a new start completes normally.
REQ-037 With MISR_SERIAL_UNLOAD_EN: signature 32'hA5A5_0F0F -> sout sequence 1,0,1,0,0,1,0,1,... over 32 cycles; done on cycle 34 after the final word.
